// File: rtl/fb_rect_fill.sv
// Solid-colour rectangle fill into a ping/pong SDRAM framebuffer via the controller write port.
// Optional clipping to the display is enabled by defining FB_RECT_CLIP_EN.
module fb_rect_fill #(
  parameter int H_DISP        = 1024,
  parameter int V_DISP        = 600,
  parameter int PIX_W         = 24,
  parameter int ADDR_W        = 32,
  parameter int LOAD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sys_vaild,
  input  logic              cmd_en,
  input  logic [15:0]       cmd_x,
  input  logic [15:0]       cmd_y,
  input  logic [15:0]       cmd_w,
  input  logic [15:0]       cmd_h,
  input  logic [PIX_W-1:0]  cmd_pixel,
  input  logic              cmd_buf,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] base1,
  input  logic              wr_ready,
  output logic              sys_load,
  output logic              sys_we,
  output logic [PIX_W-1:0]  sys_data,
  output logic [ADDR_W-1:0] sys_addr_min,
  output logic [ADDR_W-1:0] sys_addr_max,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_LOAD, S_SETTLE, S_WRITE, S_NEXT, S_DONE, S_WAIT_REL
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [ADDR_W-1:0]   base_q, base_d, row_addr_q, row_addr_d;
  logic [15:0]         rows_left_q, rows_left_d, cnt_q, cnt_d, px_cnt_q, px_cnt_d;
  logic                load_q, load_d, we_en_q, we_en_d, busy_q, busy_d, done_q, done_d;
  logic [PIX_W-1:0]    data_q, data_d;
  logic [ADDR_W-1:0]   addr_min_q, addr_min_d, addr_max_q, addr_max_d;
  logic [15:0]         w_clip, h_clip;
  logic                last_px;

`ifdef FB_RECT_CLIP_EN
  logic [31:0] x_ext, y_ext, w_ext, h_ext, w_room, h_room;
  always_comb begin
    x_ext  = {16'd0, cmd_x};
    y_ext  = {16'd0, cmd_y};
    w_ext  = {16'd0, cmd_w};
    h_ext  = {16'd0, cmd_h};
    w_room = 32'(H_DISP) - x_ext;
    h_room = 32'(V_DISP) - y_ext;
    w_clip = cmd_w;
    h_clip = cmd_h;
    if (x_ext >= 32'(H_DISP) || y_ext >= 32'(V_DISP)) begin
      w_clip = 16'd0;
      h_clip = 16'd0;
    end else begin
      if (w_ext > w_room) w_clip = w_room[15:0];
      if (h_ext > h_room) h_clip = h_room[15:0];
    end
  end
`else
  assign w_clip = cmd_w;
  assign h_clip = cmd_h;
`endif

  // FIFO handshake: a word transfers on every cycle sys_we is high; wr_ready may drop at any time.
  assign sys_we    = we_en_q & wr_ready;
  assign last_px   = (px_cnt_q == w_q - 16'd1);
  assign sys_load  = load_q;
  assign sys_data  = data_q;
  assign sys_addr_min = addr_min_q;
  assign sys_addr_max = addr_max_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      pix_q       <= '0;
      base_q      <= '0;
      row_addr_q  <= '0;
      rows_left_q <= '0;
      cnt_q       <= '0;
      px_cnt_q    <= '0;
      load_q      <= 1'b0;
      we_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
      addr_min_q  <= '0;
      addr_max_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      pix_q       <= pix_d;
      base_q      <= base_d;
      row_addr_q  <= row_addr_d;
      rows_left_q <= rows_left_d;
      cnt_q       <= cnt_d;
      px_cnt_q    <= px_cnt_d;
      load_q      <= load_d;
      we_en_q     <= we_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      data_q      <= data_d;
      addr_min_q  <= addr_min_d;
      addr_max_q  <= addr_max_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (cmd_en && sys_vaild) state_d = S_LATCH;
      S_LATCH:    state_d = (w_q == 16'd0 || h_q == 16'd0) ? S_DONE : S_LOAD;
      S_LOAD:     if (cnt_q == 16'(LOAD_CYCLES - 1)) state_d = S_SETTLE;
      S_SETTLE:   if (cnt_q == 16'(SETTLE_CYCLES - 1)) state_d = S_WRITE;
      S_WRITE:    if (sys_we && last_px) state_d = S_NEXT;
      S_NEXT:     state_d = (rows_left_q == 16'd1) ? S_DONE : S_LOAD;
      S_DONE:     state_d = S_WAIT_REL;
      S_WAIT_REL: if (!cmd_en) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath: command latch, row address walk and the cycle/pixel counters.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    pix_d       = pix_q;
    base_d      = base_q;
    row_addr_d  = row_addr_q;
    rows_left_d = rows_left_q;
    px_cnt_d    = px_cnt_q;
    cnt_d       = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    case (state_q)
      S_IDLE: if (cmd_en && sys_vaild) begin
        x_d    = cmd_x;
        y_d    = cmd_y;
        w_d    = w_clip;
        h_d    = h_clip;
        pix_d  = cmd_pixel;
        base_d = cmd_buf ? base1 : base0;
      end
      S_LATCH: begin
        row_addr_d  = base_q + ADDR_W'(y_q) * ADDR_W'(H_DISP) + ADDR_W'(x_q);
        rows_left_d = h_q;
      end
      S_SETTLE: px_cnt_d = 16'd0;
      S_WRITE:  if (sys_we) px_cnt_d = px_cnt_q + 16'd1;
      S_NEXT: begin
        row_addr_d  = row_addr_q + ADDR_W'(H_DISP);
        rows_left_d = rows_left_q - 16'd1;
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    load_d     = (state_d == S_LOAD);
    we_en_d    = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE) && (state_d != S_WAIT_REL);
    done_d     = (state_d == S_DONE);
    data_d     = (state_d == S_WRITE) ? pix_q : data_q;
    addr_min_d = addr_min_q;
    addr_max_d = addr_max_q;
    if (state_d == S_LOAD) begin
      addr_min_d = row_addr_d;
      addr_max_d = base_q + ADDR_W'(H_DISP * V_DISP);
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: scoreboard of expected load addresses and write words,
// popped by a monitor as the DUT issues sys_load pulses and sys_we strobes.
module tb_fb_rect_fill;
  localparam int H  = 1024;
  localparam int V  = 600;
  localparam int PW = 24;
  localparam int AW = 32;
  localparam int LC = 2;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sys_vaild = 1'b0;
  logic          cmd_en = 1'b0;
  logic [15:0]   cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [PW-1:0] cmd_pixel = '0;
  logic          cmd_buf = 1'b0;
  logic [AW-1:0] base0 = '0, base1 = '0;
  logic          wr_ready = 1'b1;
  logic          sys_load, sys_we, busy, done;
  logic [PW-1:0] sys_data;
  logic [AW-1:0] sys_addr_min, sys_addr_max;
  logic [2:0]    dbg_state;

  fb_rect_fill #(.H_DISP(H), .V_DISP(V), .PIX_W(PW), .ADDR_W(AW),
                 .LOAD_CYCLES(LC), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .sys_vaild(sys_vaild), .cmd_en(cmd_en),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_pixel(cmd_pixel), .cmd_buf(cmd_buf), .base0(base0), .base1(base1),
    .wr_ready(wr_ready), .sys_load(sys_load), .sys_we(sys_we), .sys_data(sys_data),
    .sys_addr_min(sys_addr_min), .sys_addr_max(sys_addr_max),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  logic [AW-1:0] exp_addr_q[$];
  logic [PW-1:0] exp_data_q[$];
  logic [AW-1:0] exp_max = '0;
  logic [AW-1:0] mon_addr;
  logic [PW-1:0] mon_data;
  int load_cnt = 0, we_cnt = 0, first_we_cyc = -1, last_we_cyc = -1, load_len = 0;
  logic load_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      load_prev = 1'b0;
      load_len  = 0;
    end else begin
      if (sys_load) begin
        if (!load_prev) begin
          load_cnt++;
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL load_addr: unexpected load, addr_min=%0d expected none", sys_addr_min);
          end else begin
            mon_addr = exp_addr_q.pop_front();
            if (sys_addr_min !== mon_addr) begin
              errors++;
              $display("FAIL load_addr: addr_min=%0d expected %0d", sys_addr_min, mon_addr);
            end
          end
          checks++;
          if (sys_addr_max !== exp_max) begin
            errors++;
            $display("FAIL load_max: addr_max=%0d expected %0d", sys_addr_max, exp_max);
          end
        end
        load_len++;
      end else if (load_prev) begin
        checks++;
        if (load_len != LC) begin
          errors++;
          $display("FAIL load_len: sys_load high %0d cycles expected %0d", load_len, LC);
        end
        load_len = 0;
      end
      load_prev = sys_load;
      if (sys_we) begin
        we_cnt++;
        if (first_we_cyc < 0) first_we_cyc = cyc;
        last_we_cyc = cyc;
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL we_data: unexpected strobe, data=%h expected none", sys_data);
        end else begin
          mon_data = exp_data_q.pop_front();
          if (sys_data !== mon_data) begin
            errors++;
            $display("FAIL we_data: data=%h expected %h", sys_data, mon_data);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic clear_counts();
    load_cnt = 0;
    we_cnt = 0;
    first_we_cyc = -1;
    last_we_cyc = -1;
  endtask

  task automatic push_rect(input int x, input int y, input int w, input int h,
                           input logic [PW-1:0] p, input logic [AW-1:0] base);
    int ew, eh;
    ew = w;
    eh = h;
`ifdef FB_RECT_CLIP_EN
    if (x >= H || y >= V) begin
      ew = 0;
      eh = 0;
    end else begin
      if (ew > H - x) ew = H - x;
      if (eh > V - y) eh = V - y;
    end
`endif
    exp_max = base + AW'(H * V);
    if (ew != 0 && eh != 0)
      for (int r = 0; r < eh; r++) begin
        exp_addr_q.push_back(base + AW'(y) * AW'(H) + AW'(x) + AW'(r * H));
        for (int i = 0; i < ew; i++) exp_data_q.push_back(p);
      end
  endtask

  task automatic issue(input int x, input int y, input int w, input int h,
                       input logic [PW-1:0] p, input logic b);
    @(posedge clk);
    #1;
    cmd_x = 16'(x);
    cmd_y = 16'(y);
    cmd_w = 16'(w);
    cmd_h = 16'(h);
    cmd_pixel = p;
    cmd_buf = b;
    cmd_en = 1'b1;
  endtask

  // k=1 is the cycle after the edge that accepts the command.
  task automatic wait_done(input int budget, input bit toggle, output int load_k, output int done_k);
    load_k = 0;
    done_k = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (toggle) wr_ready = ~wr_ready;
      @(negedge clk);
      if (sys_load && load_k == 0) load_k = k;
      if (done) begin
        done_k = k;
        break;
      end
    end
    checks++;
    if (done_k == 0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic finish_cmd(input string name);
    cmd_en = 1'b0;
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    checks++;
    if (exp_addr_q.size() != 0 || exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d loads and %0d words outstanding, expected 0 and 0",
               name, exp_addr_q.size(), exp_data_q.size());
      exp_addr_q.delete();
      exp_data_q.delete();
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_load", int'(sys_load), 0);
    check_int("rst_we", int'(sys_we), 0);
    check_int("rst_data", int'(sys_data), 0);
    check_int("rst_min", int'(sys_addr_min), 0);
    check_int("rst_max", int'(sys_addr_max), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_done", int'(done), 0);
    rst_n = 1'b1;
    sys_vaild = 1'b1;
  endtask

  task automatic test_basic();
    int lk, dk, bad;
    clear_counts();
    base0 = 32'd0;
    base1 = 32'h0020_0000;
    exp_max = 32'd614400;
    exp_addr_q.push_back(32'd2058);
    exp_addr_q.push_back(32'd3082);
    exp_addr_q.push_back(32'd4106);
    for (int i = 0; i < 12; i++) exp_data_q.push_back(24'h123456);
    issue(10, 2, 4, 3, 24'h123456, 1'b0);
    wait_done(200, 1'b0, lk, dk);
    check_int("basic_load_latency", lk, 2);
    check_int("basic_done_cycle", dk, 1 + 3 * (4 + LC + SC + 1) + 1);
    check_int("basic_busy_at_done", int'(busy), 1);
    @(negedge clk);
    check_int("basic_done_pulse", int'(done), 0);
    check_int("basic_busy_fall", int'(busy), 0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || sys_load || done) bad++;
    end
    check_int("basic_no_retrigger", bad, 0);
    check_int("basic_loads", load_cnt, 3);
    check_int("basic_strobes", we_cnt, 12);
    finish_cmd("basic");
  endtask

  task automatic test_buf_select();
    int lk, dk;
    clear_counts();
    base0 = 32'h0000_5000;
    base1 = 32'h0010_0000;
    exp_max = 32'h0010_0000 + 32'd614400;
    exp_addr_q.push_back(32'h0010_080A);
    exp_addr_q.push_back(32'h0010_080A + 32'd1024);
    exp_addr_q.push_back(32'h0010_080A + 32'd2048);
    for (int i = 0; i < 12; i++) exp_data_q.push_back(24'h123456);
    issue(10, 2, 4, 3, 24'h123456, 1'b1);
    wait_done(200, 1'b0, lk, dk);
    check_int("buf1_strobes", we_cnt, 12);
    finish_cmd("buf1");
  endtask

  task automatic test_stall();
    int lk, dk;
    clear_counts();
    base0 = 32'h0000_0400;
    push_rect(5, 7, 8, 1, 24'hABCDEF, base0);
    issue(5, 7, 8, 1, 24'hABCDEF, 1'b0);
    wait_done(200, 1'b1, lk, dk);
    check_int("stall_strobes", we_cnt, 8);
    check_int("stall_span", last_we_cyc - first_we_cyc + 1, 15);
    finish_cmd("stall");
  endtask

  task automatic test_zero();
    int lk, dk;
    clear_counts();
    issue(3, 3, 0, 5, 24'h00FF00, 1'b0);
    wait_done(50, 1'b0, lk, dk);
    check_int("zero_w_done_cycle", dk, 2);
    finish_cmd("zero_w");
    issue(3, 3, 6, 0, 24'h00FF00, 1'b0);
    wait_done(50, 1'b0, lk, dk);
    check_int("zero_h_done_cycle", dk, 2);
    check_int("zero_loads", load_cnt, 0);
    check_int("zero_strobes", we_cnt, 0);
    finish_cmd("zero_h");
  endtask

  task automatic test_edge_rect();
    int lk, dk;
    clear_counts();
    base0 = 32'd0;
    push_rect(1020, 598, 10, 10, 24'h0F0F0F, base0);
    issue(1020, 598, 10, 10, 24'h0F0F0F, 1'b0);
    wait_done(600, 1'b0, lk, dk);
`ifdef FB_RECT_CLIP_EN
    check_int("edge_loads", load_cnt, 2);
    check_int("edge_strobes", we_cnt, 8);
`else
    check_int("edge_loads", load_cnt, 10);
    check_int("edge_strobes", we_cnt, 100);
`endif
    finish_cmd("edge");
  endtask

  task automatic test_sys_vaild();
    int lk, dk, bad;
    clear_counts();
    sys_vaild = 1'b0;
    issue(0, 1, 3, 1, 24'h777777, 1'b0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || sys_load) bad++;
    end
    check_int("vaild_low_blocks", bad, 0);
    push_rect(0, 1, 3, 1, 24'h777777, base0);
    sys_vaild = 1'b1;
    @(posedge clk);
    #1;
    sys_vaild = 1'b0;
    wait_done(100, 1'b0, lk, dk);
    check_int("vaild_drop_done_cycle", dk, 1 + (3 + LC + SC + 1) + 1 - 1);
    check_int("vaild_drop_strobes", we_cnt, 3);
    sys_vaild = 1'b1;
    finish_cmd("vaild");
  endtask

  task automatic test_reset_mid();
    int lk, dk, guard;
    clear_counts();
    base0 = 32'h0000_1000;
    push_rect(2, 4, 4, 4, 24'h5A5A5A, base0);
    issue(2, 4, 4, 4, 24'h5A5A5A, 1'b0);
    guard = 0;
    while (load_cnt < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_int("mid_reached_row2", int'(load_cnt >= 2), 1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_int("mid_rst_load", int'(sys_load), 0);
    check_int("mid_rst_we", int'(sys_we), 0);
    check_int("mid_rst_data", int'(sys_data), 0);
    check_int("mid_rst_min", int'(sys_addr_min), 0);
    check_int("mid_rst_max", int'(sys_addr_max), 0);
    check_int("mid_rst_busy", int'(busy), 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(posedge clk);
    clear_counts();
    push_rect(2, 4, 4, 4, 24'h5A5A5A, base0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_done(200, 1'b0, lk, dk);
    check_int("mid_restart_latency", lk, 2);
    check_int("mid_restart_done_cycle", dk, 1 + 4 * (4 + LC + SC + 1) + 1);
    check_int("mid_restart_loads", load_cnt, 4);
    check_int("mid_restart_strobes", we_cnt, 16);
    finish_cmd("mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_buf_select();
    test_stall();
    test_zero();
    test_edge_rect();
    test_sys_vaild();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_rect_fill.md
# fb_rect_fill

Parametrised rectangle-fill engine that writes a solid-colour rectangle into an SDRAM framebuffer through the write port of the two-port SDRAM controller. It replaces the single-span LCD control writer: rectangles are width × height rather than a linear span, and each command selects one of two framebuffer bases (ping/pong). Display size and pixel width are parameters. It sits between the CPU-facing draw registers and the controller's write FIFO, in the SDRAM controller clock domain.

## Interface
- H_DISP, 1024, display width in pixels (row pitch).
- V_DISP, 600, display height in lines.
- PIX_W, 24, pixel width in bits.
- ADDR_W, 32, SDRAM word-address width.
- LOAD_CYCLES, 2, number of cycles `sys_load` is held high per row.
- SETTLE_CYCLES, 4, idle cycles between `sys_load` falling and the first `sys_we` of a row.

- clk  in  1  controller clock; every register in the block is clocked by it.
- rst_n  in  1  reset, asynchronous, active-low.
- sys_vaild  in  1  SDRAM init done; commands are not accepted while it is low.
- cmd_en  in  1  start request; level-sensitive and must drop before the next command.
- cmd_x, cmd_y  in  16 each  top-left corner of the rectangle.
- cmd_w, cmd_h  in  16 each  rectangle width and height in pixels.
- cmd_pixel  in  PIX_W  fill colour.
- cmd_buf  in  1  buffer select: 0 = base0, 1 = base1.
- base0, base1  in  ADDR_W each  framebuffer base addresses.
- wr_ready  in  1  write FIFO can accept a word.
- sys_load  out  1  write-address load and FIFO clear.
- sys_we  out  1  write strobe.
- sys_data  out  PIX_W  write data.
- sys_addr_min, sys_addr_max  out  ADDR_W each  write window.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse when a command finishes.

## Operation
- States: IDLE, LATCH, LOAD, SETTLE, WRITE, NEXT, DONE, WAIT_REL.
- IDLE: when `cmd_en` and `sys_vaild` are both high, latch all `cmd_*` fields and the selected base, then go to LATCH.
- LATCH: compute `row_addr = base + cmd_y*H_DISP + cmd_x`, using ADDR_W-bit arithmetic with the multiply zero-extended. Set `rows_left = h`. If w == 0 or h == 0, go to DONE; otherwise go to LOAD.
- LOAD: drive `sys_addr_min = row_addr` and `sys_addr_max = base + H_DISP*V_DISP`. Hold `sys_load` high for LOAD_CYCLES cycles, then go to SETTLE.
- SETTLE: wait SETTLE_CYCLES cycles, clear `px_cnt`, then go to WRITE.
- WRITE: `sys_we = wr_ready`. On each cycle with `sys_we` high, `sys_data = pixel` and `px_cnt` increments. After the w-th accepted word, go to NEXT.
- NEXT: `row_addr += H_DISP` and `rows_left -= 1`. If `rows_left` reaches 0, go to DONE; otherwise go to LOAD.
- DONE: pulse `done` for one cycle, then go to WAIT_REL.
- WAIT_REL: return to IDLE once `cmd_en` is low. A held `cmd_en` never retriggers a command.
- `busy` is high in every state except IDLE and WAIT_REL.
- `cmd_*` changes while busy are ignored; the latched copy is used throughout.
- `sys_vaild` falling mid-command does not abort the command.
- `sys_addr_min` and `sys_addr_max` hold their last values when not in LOAD.

## Timing
- Reset values: `sys_load`=0, `sys_we`=0, `sys_data`=0, `sys_addr_min`=0, `sys_addr_max`=0, `busy`=0, `done`=0; state = IDLE.
- Reset asserted mid-command returns the block to IDLE immediately. No further strobes are issued, and partial rows are not completed.
- Start latency: `cmd_en` sampled high → `sys_load` first high 2 cycles later (IDLE, LATCH).
- Per-row overhead with `wr_ready` held high: LOAD_CYCLES + SETTLE_CYCLES + 1 (NEXT) cycles.
- Row time with `wr_ready` held high: w + LOAD_CYCLES + SETTLE_CYCLES + 1 cycles.
- `done` pulses the cycle after the final NEXT.
- `wr_ready` low stalls WRITE indefinitely; no word is lost or duplicated.
- All outputs are registered. `sys_we` is the exception: it is the registered WRITE-state flag AND `wr_ready`, so the FIFO sees acceptance in the same cycle.

## Configuration
- FB_RECT_CLIP_EN defined:
  - Before LATCH, clip the rectangle: `w' = min(w, H_DISP - x)` and `h' = min(h, V_DISP - y)`.
  - If x ≥ H_DISP or y ≥ V_DISP, the command goes straight to DONE with zero writes.
- FB_RECT_CLIP_EN undefined:
  - No clipping; addresses are computed raw.
  - Rectangles that extend past the right edge wrap into the next line.
  - Rectangles past the bottom write beyond the frame, modulo 2^ADDR_W.

## Test plan
- Reset, then x=10, y=2, w=4, h=3, pixel=0x123456, buf=0, base0=0, `wr_ready`=1 → three loads at `sys_addr_min` 2058, 3082, 4106; 12 `sys_we` strobes; `done` pulses once; `busy` falls with it.
- Same command with buf=1, base1=0x100000 → `sys_addr_min` 0x10080A first; `sys_addr_max` 0x100000+614400.
- w=8, h=1 with `wr_ready` toggling 1,0,1,0… → exactly 8 strobes spread over 15 WRITE cycles; `sys_data` constant.
- w=0, h=5 → no `sys_load`, no `sys_we`; `done` 2 cycles after accept.
- Clip build, x=1020, y=598, w=10, h=10 → 2 rows of 4 strobes each; without the macro → 10 rows of 10 strobes.
- `rst_n` low during row 2 of a 4-row fill → outputs return to their reset values asynchronously; `cmd_en` held high after reset starts a fresh command from row 0.
